outperiph_fifo: RTL and testbench

- Buffered, parametrised memory-mapped output peripheral on the CPU data bus (daddr/dwdata/dwe/drdata).
- CPU stores are pushed into a DEPTH-entry FIFO; the FIFO drains over a valid/ready stream port toward a console or character sink.
- Status, accepted-count, drop-count and control registers are readable, so software can poll for space instead of overrunning the device.

---
 rtl/outperiph_fifo.sv | 118 +++++++++++
 tb/tb_outperiph_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/outperiph_fifo.sv
// Memory-mapped output FIFO: CPU stores to DATA push bytes, head drains over tx_valid/tx_ready.
// Latency: a push at edge N is visible on tx_valid/tx_data after edge N; pop at N+1 earliest.
// Backpressure: tx_ready low holds the head; pushes to a full FIFO are dropped and counted.
module outperiph_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h0003_4560,
  parameter int          DATA_W    = 8,
  parameter int          DEPTH     = 16,
  parameter int          CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       daddr,
  input  logic [31:0]       dwdata,
  input  logic [3:0]        dwe,
  output logic [31:0]       drdata,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    DEPTH_L = LW'(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [LW-1:0]    LVL_ONE = LW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [31:0] A_DATA   = BASE_ADDR;
  localparam logic [31:0] A_STATUS = BASE_ADDR + 32'h4;
  localparam logic [31:0] A_DROP   = BASE_ADDR + 32'h8;
  localparam logic [31:0] A_CTRL   = BASE_ADDR + 32'hC;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic [CNT_W-1:0]  acc_cnt, drop_cnt;
  logic              drop_sticky, drain_en;

  logic wr, wr_data, wr_status, wr_drop, wr_ctrl;
  logic full, empty, push_ok, push_drop, pop, flush;
  logic unused_wdata;

  assign wr        = |dwe;
  assign wr_data   = wr && (daddr == A_DATA);
  assign wr_status = wr && (daddr == A_STATUS);
  assign wr_drop   = wr && (daddr == A_DROP);
  assign wr_ctrl   = wr && (daddr == A_CTRL);

  // Fullness is judged on the pre-cycle level, so a pop never makes room for a same-cycle push.
  assign full      = (level == DEPTH_L);
  assign empty     = (level == '0);
  assign push_ok   = wr_data && !full;
  assign push_drop = wr_data && full;
  assign tx_valid  = !empty && drain_en;
  assign tx_data   = mem[rd_ptr];
  assign pop       = tx_valid && tx_ready;
  assign flush     = wr_ctrl && dwdata[0];

  assign unused_wdata = ^dwdata;

  always_ff @(posedge clk) begin
    if (reset && push_ok)
      mem[wr_ptr] <= dwdata[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      acc_cnt     <= '0;
      drop_cnt    <= '0;
      drop_sticky <= 1'b0;
      drain_en    <= 1'b1;
    end else begin
      // A flush swallows any concurrent pop; that entry counts as consumed.
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
        case ({push_ok, pop})
          2'b10:   level <= level + LVL_ONE;
          2'b01:   level <= level - LVL_ONE;
          default: level <= level;
        endcase
      end
      if (push_ok) acc_cnt <= acc_cnt + CNT_ONE;
      if (push_drop) begin
        drop_sticky <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_ONE;
      end
      if (wr_status) drop_sticky <= 1'b0;
      if (wr_drop)   drop_cnt    <= '0;
      if (wr_ctrl)   drain_en    <= dwdata[1];
    end
  end

  always_comb begin
    drdata = '0;
    case (daddr)
      A_DATA: drdata = 32'(acc_cnt);
      A_STATUS: begin
        drdata[LW-1:0] = level;
        drdata[16]     = empty;
        drdata[17]     = full;
        drdata[18]     = drop_sticky;
        drdata[19]     = drain_en;
      end
      A_DROP: drdata = 32'(drop_cnt);
      A_CTRL: drdata = {30'b0, drain_en, 1'b0};
      default: drdata = '0;
    endcase
  end

endmodule

// File: tb/tb_outperiph_fifo.sv
// Directed bench for outperiph_fifo: register map, push/pop ordering, overflow, drain control, reset.
module tb_outperiph_fifo;

  localparam logic [31:0] BASE   = 32'h0003_4560;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_DROP = BASE + 32'h8;
  localparam logic [31:0] A_CTRL = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dwdata = '0;
  logic [3:0]  dwe = '0;
  logic [31:0] drdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  int vecs = 0;
  int errs = 0;
  logic [31:0] rv;

  outperiph_fifo #(
    .BASE_ADDR(BASE), .DATA_W(8), .DEPTH(16), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
    .drdata(drdata), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    daddr = addr; dwdata = data; dwe = 4'hF;
    @(negedge clk);
    dwe = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    dwe = 4'h0; daddr = addr;
    #1;
    data = drdata;
  endtask

  task automatic test_reset;
    reset = 1'b0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus_read(A_DATA, rv);
    vecs++; if (rv !== 32'h0) begin errs++; $display("FAIL reset_data: got %h expected %h", rv, 32'h0); end
    bus_read(A_STAT, rv);
    vecs++; if (rv !== 32'h0009_0000) begin errs++; $display("FAIL reset_status: got %h expected %h", rv, 32'h0009_0000); end
    bus_read(A_DROP, rv);
    vecs++; if (rv !== 32'h0) begin errs++; $display("FAIL reset_drop: got %h expected %h", rv, 32'h0); end
    bus_read(A_CTRL, rv);
    vecs++; if (rv !== 32'h2) begin errs++; $display("FAIL reset_ctrl: got %h expected %h", rv, 32'h2); end
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL reset_txvalid: got %b expected 0", tx_valid); end
  endtask

  task automatic test_basic;
    tx_ready = 1'b0;
    bus_write(A_DATA, 32'h48);
    bus_write(A_DATA, 32'h69);
    bus_read(A_STAT, rv);
    vecs++; if (rv !== 32'h0008_0002) begin errs++; $display("FAIL basic_status: got %h expected %h", rv, 32'h0008_0002); end
    tx_ready = 1'b1;
    vecs++; if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin errs++; $display("FAIL basic_head0: got v=%b d=%h expected v=1 d=48", tx_valid, tx_data); end
    @(negedge clk);
    vecs++; if (tx_valid !== 1'b1 || tx_data !== 8'h69) begin errs++; $display("FAIL basic_head1: got v=%b d=%h expected v=1 d=69", tx_valid, tx_data); end
    @(negedge clk);
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL basic_drained: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
    bus_read(A_DATA, rv);
    vecs++; if (rv !== 32'd2) begin errs++; $display("FAIL basic_acc: got %0d expected 2", rv); end
    bus_read(A_STAT, rv);
    vecs++; if (rv !== 32'h0009_0000) begin errs++; $display("FAIL basic_empty: got %h expected %h", rv, 32'h0009_0000); end
  endtask

  task automatic test_overflow;
    tx_ready = 1'b0;
    for (int i = 0; i < 18; i++) bus_write(A_DATA, 32'h41 + i);
    bus_read(A_STAT, rv);
    vecs++; if (rv !== 32'h000E_0010) begin errs++; $display("FAIL ovf_status: got %h expected %h", rv, 32'h000E_0010); end
    bus_read(A_DROP, rv);
    vecs++; if (rv !== 32'd2) begin errs++; $display("FAIL ovf_drop: got %0d expected 2", rv); end
    bus_read(A_DATA, rv);
    vecs++; if (rv !== 32'd18) begin errs++; $display("FAIL ovf_acc: got %0d expected 18", rv); end
    vecs++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errs++; $display("FAIL ovf_head: got v=%b d=%h expected v=1 d=41", tx_valid, tx_data); end
    bus_write(A_STAT, 32'h0);
    bus_read(A_STAT, rv);
    vecs++; if (rv !== 32'h000A_0010) begin errs++; $display("FAIL ovf_sticky_clr: got %h expected %h", rv, 32'h000A_0010); end
  endtask

  task automatic test_push_pop_full;
    @(negedge clk);
    tx_ready = 1'b1; daddr = A_DATA; dwdata = 32'h5A; dwe = 4'hF;
    @(negedge clk);
    dwe = 4'h0; tx_ready = 1'b0;
    bus_read(A_STAT, rv);
    vecs++; if (rv !== 32'h000C_000F) begin errs++; $display("FAIL ppf_status: got %h expected %h", rv, 32'h000C_000F); end
    bus_read(A_DROP, rv);
    vecs++; if (rv !== 32'd3) begin errs++; $display("FAIL ppf_drop: got %0d expected 3", rv); end
    bus_read(A_DATA, rv);
    vecs++; if (rv !== 32'd18) begin errs++; $display("FAIL ppf_acc: got %0d expected 18", rv); end
    tx_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      vecs++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h42 + k)) begin
        errs++; $display("FAIL ppf_order[%0d]: got v=%b d=%h expected v=1 d=%h", k, tx_valid, tx_data, 8'(8'h42 + k));
      end
      @(negedge clk);
    end
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL ppf_no_extra: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
    bus_write(A_DROP, 32'h0);
    bus_read(A_DROP, rv);
    vecs++; if (rv !== 32'd0) begin errs++; $display("FAIL drop_clear: got %0d expected 0", rv); end
    bus_write(A_STAT, 32'hFFFF_FFFF);
    bus_read(A_STAT, rv);
    vecs++; if (rv !== 32'h0009_0000) begin errs++; $display("FAIL ppf_idle: got %h expected %h", rv, 32'h0009_0000); end
  endtask

  task automatic test_drain_ctrl;
    bus_write(A_CTRL, 32'h0);
    bus_read(A_CTRL, rv);
    vecs++; if (rv !== 32'h0) begin errs++; $display("FAIL ctrl_off: got %h expected 0", rv); end
    tx_ready = 1'b1;
    bus_write(A_DATA, 32'h31);
    bus_write(A_DATA, 32'h32);
    bus_write(A_DATA, 32'h33);
    @(negedge clk);
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL hold_txvalid: got %b expected 0", tx_valid); end
    bus_read(A_STAT, rv);
    vecs++; if (rv !== 32'h0000_0003) begin errs++; $display("FAIL hold_status: got %h expected %h", rv, 32'h0000_0003); end
    bus_write(A_CTRL, 32'h1);
    bus_read(A_STAT, rv);
    vecs++; if (rv !== 32'h0001_0000) begin errs++; $display("FAIL flush_status: got %h expected %h", rv, 32'h0001_0000); end
    bus_write(A_CTRL, 32'h2);
    bus_read(A_CTRL, rv);
    vecs++; if (rv !== 32'h2) begin errs++; $display("FAIL ctrl_on: got %h expected 2", rv); end
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL flush_empty_valid: got %b expected 0", tx_valid); end
    bus_write(A_DATA, 32'h77);
    vecs++; if (tx_valid !== 1'b1 || tx_data !== 8'h77) begin errs++; $display("FAIL resume_head: got v=%b d=%h expected v=1 d=77", tx_valid, tx_data); end
    @(negedge clk);
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL resume_pop: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
    bus_read(A_DATA, rv);
    vecs++; if (rv !== 32'd22) begin errs++; $display("FAIL ctrl_acc: got %0d expected 22", rv); end
  endtask

  task automatic test_back_to_back;
    tx_ready = 1'b0;
    bus_write(A_DATA, 32'h10);
    bus_write(A_DATA, 32'h11);
    @(negedge clk);
    tx_ready = 1'b1; daddr = A_DATA; dwdata = 32'h12; dwe = 4'hF;
    @(negedge clk);
    dwe = 4'h0; tx_ready = 1'b0;
    bus_read(A_STAT, rv);
    vecs++; if (rv !== 32'h0008_0002) begin errs++; $display("FAIL b2b_status: got %h expected %h", rv, 32'h0008_0002); end
    tx_ready = 1'b1;
    vecs++; if (tx_data !== 8'h11) begin errs++; $display("FAIL b2b_head0: got %h expected 11", tx_data); end
    @(negedge clk);
    vecs++; if (tx_valid !== 1'b1 || tx_data !== 8'h12) begin errs++; $display("FAIL b2b_head1: got v=%b d=%h expected v=1 d=12", tx_valid, tx_data); end
    @(negedge clk);
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL b2b_drained: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
    bus_read(A_DATA, rv);
    vecs++; if (rv !== 32'd25) begin errs++; $display("FAIL b2b_acc: got %0d expected 25", rv); end
  endtask

  task automatic test_reset_mid;
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) bus_write(A_DATA, 32'h61 + i);
    bus_read(A_DATA, rv);
    vecs++; if (rv !== 32'd32) begin errs++; $display("FAIL mid_acc: got %0d expected 32", rv); end
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(A_STAT, rv);
    vecs++; if (rv !== 32'h0008_0005) begin errs++; $display("FAIL mid_level: got %h expected %h", rv, 32'h0008_0005); end
    vecs++; if (tx_data !== 8'h63) begin errs++; $display("FAIL mid_head: got %h expected 63", tx_data); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; tx_ready = 1'b0;
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_valid: got %b expected 0", tx_valid); end
    bus_read(A_STAT, rv);
    vecs++; if (rv !== 32'h0009_0000) begin errs++; $display("FAIL mid_rst_status: got %h expected %h", rv, 32'h0009_0000); end
    bus_read(A_DATA, rv);
    vecs++; if (rv !== 32'd0) begin errs++; $display("FAIL mid_rst_acc: got %0d expected 0", rv); end
    bus_read(A_DROP, rv);
    vecs++; if (rv !== 32'd0) begin errs++; $display("FAIL mid_rst_drop: got %0d expected 0", rv); end
    bus_read(BASE + 32'h10, rv);
    vecs++; if (rv !== 32'd0) begin errs++; $display("FAIL unmapped_read: got %h expected 0", rv); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_push_pop_full();
    test_drain_ctrl();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
